// File: rtl/io_input_pkg.sv
// Shared register indices and debounce state encoding for the input scan block.
package io_input_pkg;

  localparam logic [5:0] IDX_PORT0  = 6'd0;
  localparam logic [5:0] IDX_PORT1  = 6'd1;
  localparam logic [5:0] IDX_STATUS = 6'd2;
  localparam logic [5:0] IDX_CTRL   = 6'd3;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_CHECK  = 1'b1
  } db_state_e;

endpackage

// File: rtl/io_input_scan_ctrl_if.sv
// CPU-side register bus of the input scan block: address, strobes, read data and irq.
interface io_input_scan_ctrl_if;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] io_read_data;
  logic        irq;

  modport master (output addr, rd_en, wr_en, wr_data, input io_read_data, irq);
  modport slave  (input addr, rd_en, wr_en, wr_data, output io_read_data, irq);
endinterface

// File: rtl/io_input_debounce.sv
// One port: 2-flop synchroniser, committed value and a commit pulse.
// IO_INPUT_DEBOUNCE_EN adds the STABLE/CHECK filter; otherwise every tick commits.
module io_input_debounce
  import io_input_pkg::*;
#(
  parameter int STABLE_CNT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tick,
  input  logic [31:0] i_raw,
  output logic [31:0] o_committed,
  output logic        o_commit
);

  if (STABLE_CNT < 1) begin : g_bad_cnt
    $error("STABLE_CNT must be >= 1");
  end

  logic [31:0] r_sync1, r_sync2, r_committed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign o_committed = r_committed;

`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  db_state_e        r_state;
  logic [31:0]      r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff, w_new, w_done;

  // w_new: this tick starts a fresh run (count restarts at 1)
  assign w_diff   = (r_sync2 != r_committed);
  assign w_new    = (r_state == DB_STABLE) || (r_sync2 != r_cand);
  assign w_done   = w_new ? (STABLE_CNT == 1) : (r_cnt == CNT_LAST);
  assign o_commit = i_tick && w_diff && w_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= DB_STABLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_committed <= '0;
    end else if (i_tick) begin
      if (!w_diff) begin
        r_state <= DB_STABLE;
        r_cnt   <= '0;
      end else if (w_done) begin
        r_committed <= r_sync2;
        r_state     <= DB_STABLE;
        r_cnt       <= '0;
      end else if (w_new) begin
        r_state <= DB_CHECK;
        r_cand  <= r_sync2;
        r_cnt   <= CNT_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign o_commit = i_tick && (r_sync2 != r_committed);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_committed <= '0;
    else if (i_tick) r_committed <= r_sync2;
  end
`endif

endmodule

// File: rtl/io_input_scan_ctrl.sv
// Two-port scanned input controller with pending/mask/irq registers.
// Debounce filtering is enabled by defining IO_INPUT_DEBOUNCE_EN.
module io_input_scan_ctrl
  import io_input_pkg::*;
#(
  parameter int SCAN_DIV   = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                 io_clk,
  input  logic                 resetn,
  input  logic [31:0]          in_port0,
  input  logic [31:0]          in_port1,
  io_input_scan_ctrl_if.slave  bus
);

  if (SCAN_DIV < 1) begin : g_bad_div
    $error("SCAN_DIV must be >= 1");
  end

  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

  logic [SC_W-1:0]  r_scan_cnt;
  logic             w_tick;
  logic [1:0][31:0] w_raw, w_committed;
  logic [1:0]       w_commit, w_rd_clr;
  logic [1:0]       r_pending, r_mask;
  logic             r_irq;
  logic [5:0]       w_idx;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_tick = (r_scan_cnt == SC_LAST);

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) r_scan_cnt <= '0;
    else         r_scan_cnt <= w_tick ? '0 : r_scan_cnt + SC_W'(1);
  end

  assign w_raw = {in_port1, in_port0};

  for (genvar n = 0; n < 2; n++) begin : g_port
    io_input_debounce #(.STABLE_CNT(STABLE_CNT)) u_db (
      .i_clk       (io_clk),
      .i_rst_n     (resetn),
      .i_tick      (w_tick),
      .i_raw       (w_raw[n]),
      .o_committed (w_committed[n]),
      .o_commit    (w_commit[n])
    );
  end

  assign w_idx       = bus.addr[7:2];
  assign w_rd_clr[0] = bus.rd_en && (w_idx == IDX_PORT0);
  assign w_rd_clr[1] = bus.rd_en && (w_idx == IDX_PORT1);
  assign w_unused    = ^{bus.addr[31:8], bus.addr[1:0], bus.wr_data[31:2]};

  // A commit on the same edge as a read-clear keeps the pending bit set
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= w_commit | (r_pending & ~w_rd_clr);
      if (bus.wr_en && (w_idx == IDX_CTRL)) r_mask <= bus.wr_data[1:0];
      r_irq <= |(r_pending & r_mask);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      IDX_PORT0:  w_rdata = w_committed[0];
      IDX_PORT1:  w_rdata = w_committed[1];
      IDX_STATUS: w_rdata = {30'b0, r_pending};
      IDX_CTRL:   w_rdata = {16'b0, 8'b0, 6'b0, r_mask};
      default:    w_rdata = '0;
    endcase
  end

  assign bus.io_read_data = w_rdata;
  assign bus.irq          = r_irq;

endmodule

// File: tb/tb_io_input_scan_ctrl.sv
// Directed bench for io_input_scan_ctrl; expectations follow IO_INPUT_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_io_input_scan_ctrl;

`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int CT = 3;
`else
  localparam int CT = 1;
`endif

  logic        io_clk   = 1'b0;
  logic        resetn   = 1'b0;
  logic [31:0] in_port0 = '0;
  logic [31:0] in_port1 = '0;
  int          total = 0;
  int          bad   = 0;
  int          cyc;

  io_input_scan_ctrl_if bus();

  io_input_scan_ctrl #(.SCAN_DIV(4), .STABLE_CNT(3)) dut (
    .io_clk   (io_clk),
    .resetn   (resetn),
    .in_port0 (in_port0),
    .in_port1 (in_port1),
    .bus      (bus)
  );

  always #10 io_clk = ~io_clk;

  // edges since reset release; multiples of 4 are scan-tick edges
  always @(posedge io_clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;

  task automatic step();
    @(posedge io_clk); #1;
  endtask

  task automatic step_to(input int t);
    int g = 0;
    while (cyc != t && g < 500) begin step(); g++; end
    if (cyc != t) begin
      total++; bad++;
      $display("FAIL step_to: cyc=%0d want=%0d", cyc, t);
    end
  endtask

  // first tick edge that sees an input changed after edge j, plus the filter run
  function automatic int next_commit(input int j);
    return ((j + 6) / 4) * 4 + 4 * (CT - 1);
  endfunction

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a; #1; d = bus.io_read_data;
  endtask

  task automatic clr(input int idx);
    bus.addr = 32'(idx) << 2; bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] v);
    bus.addr = 32'(idx) << 2; bus.wr_data = v; bus.wr_en = 1'b1; step(); bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    in_port0 = 32'hA5A5_0001;
    step(); step();
    for (int a = 0; a < 4; a++) begin
      rd(32'(a) << 2, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_rd%0d: got %h exp 0", a, d); end
    end
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b exp 0", bus.irq); end
    @(posedge io_clk); #1; resetn = 1'b1;
  endtask

  task automatic test_commit();
    logic [31:0] d;
    step_to(4 * CT - 1);
    rd(32'h0, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL pre_commit_p0: got %h exp 0", d); end
    rd(32'h8, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL pre_commit_status: got %h exp 0", d); end
    step();
    rd(32'h0, d); total++;
    if (d !== 32'hA5A5_0001) begin bad++; $display("FAIL commit_p0: got %h exp a5a50001", d); end
    rd(32'h8, d); total++;
    if (d !== 32'h1) begin bad++; $display("FAIL commit_status: got %h exp 1", d); end
    rd(32'h4, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL commit_p1: got %h exp 0", d); end
    rd(32'h14, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL unmapped_rd: got %h exp 0", d); end
    rd(32'h100, d); total++;
    if (d !== 32'hA5A5_0001) begin bad++; $display("FAIL alias_rd: got %h exp a5a50001", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int c;
    clr(0);
    rd(32'h8, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rdclr_status: got %h exp 0", d); end
    wr(3, 32'h1);
    rd(32'hC, d); total++;
    if (d !== 32'h1) begin bad++; $display("FAIL mask_wr: got %h exp 1", d); end
    wr(0, 32'h2);
    rd(32'hC, d); total++;
    if (d !== 32'h1) begin bad++; $display("FAIL wr_ignored: got %h exp 1", d); end
    in_port0 = 32'h0000_00FF;
    c = next_commit(cyc);
    step_to(c - 1);
    rd(32'h8, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL irq_pre_status: got %h exp 0", d); end
    step();
    rd(32'h8, d); total++;
    if (d !== 32'h1) begin bad++; $display("FAIL irq_status: got %h exp 1", d); end
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL irq_lag: got %b exp 0", bus.irq); end
    step(); total++;
    if (bus.irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b exp 1", bus.irq); end
    clr(0);
    rd(32'h8, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL irq_clr_status: got %h exp 0", d); end
    total++;
    if (bus.irq !== 1'b1) begin bad++; $display("FAIL irq_hold: got %b exp 1", bus.irq); end
    step(); total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL irq_drop: got %b exp 0", bus.irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    int m;
    m = ((cyc + 4) / 4) * 4;
    step_to(m);
    in_port1 = 32'h1;
    step_to(m + 4);
    rd(32'h4, d); total++;
    if (d !== ((CT == 1) ? 32'h1 : 32'h0)) begin bad++; $display("FAIL glitch_p1_mid: got %h", d); end
    in_port1 = 32'h0;
    step_to(m + 8);
    rd(32'h4, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL glitch_p1_end: got %h exp 0", d); end
    step_to(m + 16);
    rd(32'h8, d); total++;
    if (d !== ((CT == 1) ? 32'h2 : 32'h0)) begin bad++; $display("FAIL glitch_status: got %h", d); end
    clr(1);
    rd(32'h8, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL glitch_clr: got %h exp 0", d); end
  endtask

  task automatic test_same_edge();
    logic [31:0] d;
    int c;
    in_port0 = 32'h1234_5678;
    c = next_commit(cyc);
    step_to(c - 1);
    bus.addr = 32'h0; bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    rd(32'h8, d); total++;
    if (d !== 32'h1) begin bad++; $display("FAIL set_wins: got %h exp 1", d); end
    rd(32'h0, d); total++;
    if (d !== 32'h1234_5678) begin bad++; $display("FAIL same_p0: got %h exp 12345678", d); end
    step(); total++;
    if (bus.irq !== 1'b1) begin bad++; $display("FAIL same_irq: got %b exp 1", bus.irq); end
    clr(0);
  endtask

  task automatic test_both_ports();
    logic [31:0] d;
    int c;
    in_port0 = 32'h0;
    in_port1 = 32'hDEAD_BEEF;
    c = next_commit(cyc);
    step_to(c - 1);
    rd(32'h8, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL both_pre: got %h exp 0", d); end
    step();
    rd(32'h8, d); total++;
    if (d !== 32'h3) begin bad++; $display("FAIL both_status: got %h exp 3", d); end
    rd(32'h0, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL both_p0: got %h exp 0", d); end
    rd(32'h4, d); total++;
    if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL both_p1: got %h exp deadbeef", d); end
    wr(3, 32'h2);
    rd(32'hC, d); total++;
    if (d !== 32'h2) begin bad++; $display("FAIL mask_p1: got %h exp 2", d); end
    clr(0);
    total++;
    if (bus.irq !== 1'b1) begin bad++; $display("FAIL irq_p1: got %b exp 1", bus.irq); end
    clr(1);
    step();
    rd(32'h8, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL both_clr: got %h exp 0", d); end
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL irq_p1_drop: got %b exp 0", bus.irq); end
  endtask

  task automatic test_reset_mid_check();
    logic [31:0] d;
    int f;
    in_port0 = 32'h0000_0C0C;
    f = ((cyc + 6) / 4) * 4;
    step_to(f + 4);
    resetn = 1'b0; #1;
    for (int a = 0; a < 4; a++) begin
      rd(32'(a) << 2, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL midrst_rd%0d: got %h exp 0", a, d); end
    end
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL midrst_irq: got %b exp 0", bus.irq); end
    in_port1 = 32'h0;
    step(); step();
    @(posedge io_clk); #1; resetn = 1'b1;
    step_to(4 * CT - 1);
    rd(32'h0, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL midrst_early: got %h exp 0", d); end
    rd(32'h8, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL midrst_early_st: got %h exp 0", d); end
    step();
    rd(32'h0, d); total++;
    if (d !== 32'h0000_0C0C) begin bad++; $display("FAIL midrst_commit: got %h exp 00000c0c", d); end
    rd(32'h8, d); total++;
    if (d !== 32'h1) begin bad++; $display("FAIL midrst_status: got %h exp 1", d); end
    step(); total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL midrst_mask: got %b exp 0", bus.irq); end
  endtask

  initial begin
    bus.addr = '0; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0;
    test_reset();
    test_commit();
    test_irq();
    test_glitch();
    test_same_edge();
    test_both_ports();
    test_reset_mid_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
